// File: rtl/atomic_counter_pkg.sv
// Shared types and sizing helpers for the atomic counter bank.
package atomic_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_e;

  // Number of bus beats needed to return one counter.
  function automatic int unsigned beats_f(input int unsigned cnt_w, input int unsigned bus_w);
    return cnt_w / bus_w;
  endfunction

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/atomic_counter_cell.sv
// One event counter: clear beats increment; wraps or saturates at all-ones.
module atomic_counter_cell #(
  parameter int unsigned CNT_W = 64,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_next_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then increment with wrap/saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (trig_i) begin
      if (&cnt_q) begin
        cnt_d = SAT ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Post-update value lets a same-cycle snapshot see this cycle's event.
  assign cnt_next_c = cnt_d;

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/atomic_counter_bank.sv
// Bank of wide event counters read atomically over a narrow beat-based port.
module atomic_counter_bank
  import atomic_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned BUS_W   = 32,
  parameter bit          SAT     = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CNT-1:0]                   trig_i,
  input  logic [NUM_CNT-1:0]                   clr_i,
  input  logic                                 req_i,
  input  logic                                 atomic_i,
  input  logic [atomic_counter_pkg::idx_w_f(NUM_CNT)-1:0] sel_i,
  output logic                                 ack_o,
  output logic [BUS_W-1:0]                     data_o,
  output logic                                 last_o,
  output logic                                 err_o,
  output logic                                 busy_o
);

  localparam int unsigned BEATS  = beats_f(CNT_W, BUS_W);
  localparam int unsigned SEL_W  = idx_w_f(NUM_CNT);
  localparam int unsigned BIDX_W = idx_w_f(BEATS);

  logic [CNT_W-1:0]  cnt_next [NUM_CNT];
  logic [CNT_W-1:0]  sel_cnt_c;
  logic              sel_ok_c;
  logic [BUS_W-1:0]  beat_c;

  state_e            state_q, state_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic [CNT_W-1:0]  snap_q, snap_d;
  logic              ack_q, ack_d;
  logic [BUS_W-1:0]  data_q, data_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
    atomic_counter_cell #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) u_cell (
      .clk        (clk),
      .rst_n      (reset),
      .trig_i     (trig_i[g]),
      .clr_i      (clr_i[g]),
      .cnt_next_c (cnt_next[g])
    );
  end

  // Select the post-update counter; unmatched select codes are flagged invalid.
  always_comb begin
    sel_cnt_c = '0;
    sel_ok_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (sel_i == SEL_W'(i)) begin
        sel_cnt_c = cnt_next[i];
        sel_ok_c  = 1'b1;
      end
    end
  end

  // Pick the snapshot beat addressed by the beat index.
  always_comb begin
    beat_c = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (bidx_q == BIDX_W'(b)) begin
        beat_c = snap_q[b*BUS_W +: BUS_W];
      end
    end
  end

  // Read FSM: atomic request opens a snapshot, continuations stream its beats.
  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    snap_d  = snap_q;
    ack_d   = 1'b0;
    data_d  = '0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    if (req_i) begin
      ack_d = 1'b1;
      if (atomic_i) begin
        if (sel_ok_c) begin
          snap_d  = sel_cnt_c;
          data_d  = sel_cnt_c[BUS_W-1:0];
          bidx_d  = BIDX_W'(1);
          state_d = OPEN;
        end else begin
          err_d = 1'b1;
        end
      end else if (state_q == OPEN) begin
        data_d = beat_c;
        if (bidx_q == BIDX_W'(BEATS - 1)) begin
          last_d  = 1'b1;
          bidx_d  = '0;
          state_d = IDLE;
        end else begin
          bidx_d = bidx_q + BIDX_W'(1);
        end
      end else begin
        err_d = 1'b1;
      end
    end
    busy_d = (state_d == OPEN);
  end

  // State, snapshot and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      bidx_q  <= '0;
      snap_q  <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      snap_q  <= snap_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;
  assign last_o = last_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Scoreboard bench for atomic_counter_bank over four parameterisations.
// d0: 4x8b/4b wrap  d1: 3x8b/4b saturate  d2: 2x12b/4b (3 beats)  d3: defaults.
module tb_atomic_counter_bank;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        last;
    logic        err;
    logic        busy;
    string       name;
  } resp_t;

  logic        clk;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  resp_t       exp_q [4][$];

  logic [3:0]  trig [4];
  logic [3:0]  clr  [4];
  logic        req  [4];
  logic        atom [4];
  logic [1:0]  sel  [4];
  logic        rst_n[4];
  logic        ack  [4];
  logic        last [4];
  logic        err  [4];
  logic        busy [4];
  logic [3:0]  data_a, data_b, data_c;
  logic [31:0] data_d;

  atomic_counter_bank #(.NUM_CNT(4), .CNT_W(8), .BUS_W(4), .SAT(1'b0)) dut_a (
    .clk(clk), .reset(rst_n[0]), .trig_i(trig[0]), .clr_i(clr[0]),
    .req_i(req[0]), .atomic_i(atom[0]), .sel_i(sel[0]),
    .ack_o(ack[0]), .data_o(data_a), .last_o(last[0]), .err_o(err[0]), .busy_o(busy[0]));

  atomic_counter_bank #(.NUM_CNT(3), .CNT_W(8), .BUS_W(4), .SAT(1'b1)) dut_b (
    .clk(clk), .reset(rst_n[1]), .trig_i(trig[1][2:0]), .clr_i(clr[1][2:0]),
    .req_i(req[1]), .atomic_i(atom[1]), .sel_i(sel[1]),
    .ack_o(ack[1]), .data_o(data_b), .last_o(last[1]), .err_o(err[1]), .busy_o(busy[1]));

  atomic_counter_bank #(.NUM_CNT(2), .CNT_W(12), .BUS_W(4), .SAT(1'b0)) dut_c (
    .clk(clk), .reset(rst_n[2]), .trig_i(trig[2][1:0]), .clr_i(clr[2][1:0]),
    .req_i(req[2]), .atomic_i(atom[2]), .sel_i(sel[2][0:0]),
    .ack_o(ack[2]), .data_o(data_c), .last_o(last[2]), .err_o(err[2]), .busy_o(busy[2]));

  atomic_counter_bank dut_d (
    .clk(clk), .reset(rst_n[3]), .trig_i(trig[3]), .clr_i(clr[3]),
    .req_i(req[3]), .atomic_i(atom[3]), .sel_i(sel[3]),
    .ack_o(ack[3]), .data_o(data_d), .last_o(last[3]), .err_o(err[3]), .busy_o(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one DUT's outputs against the scoreboard head, or against idle zeros.
  task automatic mon(input int d, input logic a, input logic [31:0] dt,
                     input logic l, input logic e, input logic b);
    resp_t r;
    n_cmp++;
    if (exp_q[d].size() != 0 && exp_q[d][0].cyc == cyc) begin
      r = exp_q[d].pop_front();
      if (a !== 1'b1 || dt !== r.data || l !== r.last || e !== r.err || b !== r.busy) begin
        n_bad++;
        $display("FAIL %s (d%0d cyc %0d): got ack=%0b data=0x%0h last=%0b err=%0b busy=%0b, want ack=1 data=0x%0h last=%0b err=%0b busy=%0b",
                 r.name, d, cyc, a, dt, l, e, b, r.data, r.last, r.err, r.busy);
      end
    end else if (a !== 1'b0 || dt !== 32'd0 || l !== 1'b0 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_outputs (d%0d cyc %0d): got ack=%0b data=0x%0h last=%0b err=%0b, want all 0",
               d, cyc, a, dt, l, e);
    end
  endtask

  // Monitor: every DUT output is checked at the falling edge.
  always @(negedge clk) begin
    mon(0, ack[0], 32'(data_a), last[0], err[0], busy[0]);
    mon(1, ack[1], 32'(data_b), last[1], err[1], busy[1]);
    mon(2, ack[2], 32'(data_c), last[2], err[2], busy[2]);
    mon(3, ack[3], data_d,      last[3], err[3], busy[3]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Advance one clock and return all strobes to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      trig[d] = '0;
      clr[d]  = '0;
      req[d]  = 1'b0;
      atom[d] = 1'b0;
    end
  endtask

  task automatic trig_n(input int d, input int ch, input int n);
    repeat (n) begin
      trig[d][ch] = 1'b1;
      tick();
    end
  endtask

  // Drive a request for the coming edge and queue its expected response.
  task automatic issue(input int d, input logic a, input int s, input string name,
                       input logic [31:0] data, input logic l, input logic e, input logic b);
    resp_t r;
    req[d]  = 1'b1;
    atom[d] = a;
    sel[d]  = 2'(s);
    r.cyc   = cyc + 1;
    r.data  = data;
    r.last  = l;
    r.err   = e;
    r.busy  = b;
    r.name  = name;
    exp_q[d].push_back(r);
  endtask

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    for (int d = 0; d < 4; d++) begin
      rst_n[d] = 1'b0;
      sel[d]   = '0;
    end
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      chk("reset_busy", 32'(busy[d]), 32'd0);
      chk("reset_ack", 32'(ack[d]), 32'd0);
      rst_n[d] = 1'b1;
    end

    // T1: counter at 0x5F plus same-cycle trig snapshots 0x60.
    trig_n(0, 2, 95);
    trig[0][2] = 1'b1;
    issue(0, 1'b1, 2, "t1_beat0", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    issue(0, 1'b0, 0, "t1_beat1", 32'h6, 1'b1, 1'b0, 1'b0); tick();

    // T2: snapshot frozen while the counter keeps counting.
    trig_n(0, 1, 16);
    issue(0, 1'b1, 1, "t2_beat0", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    trig_n(0, 1, 10);
    chk("t2_busy_held", 32'(busy[0]), 32'd1);
    issue(0, 1'b0, 0, "t2_beat1_frozen", 32'h1, 1'b1, 1'b0, 1'b0); tick();
    issue(0, 1'b1, 1, "t2_live_beat0", 32'hA, 1'b0, 1'b0, 1'b1); tick();
    issue(0, 1'b0, 0, "t2_live_beat1", 32'h1, 1'b1, 1'b0, 1'b0); tick();

    // T3: continuation with no open read is an error; counters untouched.
    issue(0, 1'b0, 0, "t3_cont_idle_err", 32'h0, 1'b0, 1'b1, 1'b0); tick();
    issue(0, 1'b1, 2, "t3_ch2_beat0", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    issue(0, 1'b0, 0, "t3_ch2_beat1", 32'h6, 1'b1, 1'b0, 1'b0); tick();

    // T4 (wrap): clear beats trig; all-ones wraps to 0.
    clr[0][2] = 1'b1; trig[0][2] = 1'b1;
    issue(0, 1'b1, 2, "t4_clr_trig_b0", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    issue(0, 1'b0, 0, "t4_clr_trig_b1", 32'h0, 1'b1, 1'b0, 1'b0); tick();
    trig_n(0, 3, 255);
    issue(0, 1'b1, 3, "t4_ones_b0", 32'hF, 1'b0, 1'b0, 1'b1); tick();
    issue(0, 1'b0, 0, "t4_ones_b1", 32'hF, 1'b1, 1'b0, 1'b0); tick();
    trig[0][3] = 1'b1;
    issue(0, 1'b1, 3, "t4_wrap_b0", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    issue(0, 1'b0, 0, "t4_wrap_b1", 32'h0, 1'b1, 1'b0, 1'b0); tick();

    // T6: reset during an open read drops it.
    issue(0, 1'b1, 1, "t6_open_b0", 32'hA, 1'b0, 1'b0, 1'b1); tick();
    rst_n[0] = 1'b0; req[0] = 1'b1; atom[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    chk("t6_busy_after_reset", 32'(busy[0]), 32'd0);
    issue(0, 1'b0, 0, "t6_cont_err", 32'h0, 1'b0, 1'b1, 1'b0); tick();
    issue(0, 1'b1, 1, "t6_cleared_b0", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    issue(0, 1'b0, 0, "t6_cleared_b1", 32'h0, 1'b1, 1'b0, 1'b0); tick();

    // T4 (saturate): all-ones holds; clear beats trig; bad select is an error.
    trig_n(1, 0, 255);
    trig[1][0] = 1'b1;
    issue(1, 1'b1, 0, "t4_sat_b0", 32'hF, 1'b0, 1'b0, 1'b1); tick();
    issue(1, 1'b0, 0, "t4_sat_b1", 32'hF, 1'b1, 1'b0, 1'b0); tick();
    clr[1][0] = 1'b1; trig[1][0] = 1'b1;
    issue(1, 1'b1, 0, "t4_sat_clr_b0", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    issue(1, 1'b0, 0, "t4_sat_clr_b1", 32'h0, 1'b1, 1'b0, 1'b0); tick();
    trig_n(1, 0, 35);
    issue(1, 1'b1, 3, "badsel_idle", 32'h0, 1'b0, 1'b1, 1'b0); tick();
    issue(1, 1'b1, 0, "badsel_open_b0", 32'h3, 1'b0, 1'b0, 1'b1); tick();
    issue(1, 1'b1, 3, "badsel_open", 32'h0, 1'b0, 1'b1, 1'b1); tick();
    issue(1, 1'b0, 0, "badsel_open_b1", 32'h2, 1'b1, 1'b0, 1'b0); tick();

    // T5: three-beat read, then an atomic restart mid-read.
    trig_n(2, 1, 683);
    issue(2, 1'b1, 1, "t5_b0", 32'hB, 1'b0, 1'b0, 1'b1); tick();
    issue(2, 1'b0, 0, "t5_b1", 32'hA, 1'b0, 1'b0, 1'b1); tick();
    issue(2, 1'b0, 0, "t5_b2", 32'h2, 1'b1, 1'b0, 1'b0); tick();
    issue(2, 1'b1, 1, "t5_r_b0", 32'hB, 1'b0, 1'b0, 1'b1); tick();
    issue(2, 1'b0, 0, "t5_r_b1", 32'hA, 1'b0, 1'b0, 1'b1); tick();
    trig[2][1] = 1'b1;
    issue(2, 1'b1, 1, "t5_restart_b0", 32'hC, 1'b0, 1'b0, 1'b1); tick();
    issue(2, 1'b0, 0, "t5_restart_b1", 32'hA, 1'b0, 1'b0, 1'b1); tick();
    issue(2, 1'b0, 0, "t5_restart_b2", 32'h2, 1'b1, 1'b0, 1'b0); tick();
    issue(2, 1'b1, 0, "t5_ch0_b0", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    issue(2, 1'b0, 0, "t5_ch0_b1", 32'h0, 1'b0, 1'b0, 1'b1); tick();
    issue(2, 1'b0, 0, "t5_ch0_b2", 32'h0, 1'b1, 1'b0, 1'b0); tick();

    // Default parameters: 64-bit counter in two 32-bit beats.
    trig_n(3, 3, 3);
    issue(3, 1'b1, 3, "def_b0", 32'h3, 1'b0, 1'b0, 1'b1); tick();
    issue(3, 1'b0, 0, "def_b1", 32'h0, 1'b1, 1'b0, 1'b0); tick();

    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      chk("scoreboard_drained", 32'(exp_q[d].size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
